// File: rtl/xpu_mac_pkg.sv
// Shared definitions for the xpu MAC TX-path sequencers: FSM state encoding,
// LFSR feedback polynomial and a small exponent clamp helper.
package xpu_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIFS    = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_GRANT   = 2'd3
  } mac_state_e;

  // Right-shift Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic logic [3:0] clamp_exp(input logic [3:0] e, input logic [3:0] lim);
    return (e > lim) ? lim : e;
  endfunction

endpackage

// File: rtl/mac_lfsr16.sv
// Free-running 16-bit Galois LFSR; exposes only the low OUT_W bits to the user.
module mac_lfsr16
  import xpu_mac_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [OUT_W-1:0] o_q
);

  logic [15:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_q <= SEED;
    else if (i_en) r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_POLY : 16'h0000);
  end

  assign o_q = r_q[OUT_W-1:0];

endmodule

// File: rtl/csma_backoff_ctl.sv
// CSMA medium-access sequencer: DIFS wait, frozen/resumable binary-exponential
// backoff, TX grant, contention-window growth and retry-limit drop.
module csma_backoff_ctl
  import xpu_mac_pkg::*;
#(
  parameter int          SLOT_W      = 10,
  parameter int          TIMER_W     = 12,
  parameter int          RETRY_LIMIT = 7,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ch_idle,
  input  logic               tx_req,
  input  logic               tx_done,
  input  logic               tx_ok,
  input  logic [TIMER_W-1:0] difs_top,
  input  logic [TIMER_W-1:0] slot_top,
  input  logic [3:0]         cw_exp_min,
  input  logic [3:0]         cw_exp_max,
  output logic               tx_grant,
  output logic               tx_drop,
  output logic [3:0]         cw_exp,
  output logic [SLOT_W-1:0]  slots_left,
  output logic [2:0]         retry_cnt,
  output logic [1:0]         state
);

  mac_state_e         r_state;
  logic               r_grant, r_drop, r_bo_valid;
  logic [3:0]         r_cw_exp;
  logic [SLOT_W-1:0]  r_slots;
  logic [2:0]         r_retry;
  logic [TIMER_W-1:0] r_timer;

  logic [SLOT_W-1:0]  w_lfsr, w_mask;
  logic [TIMER_W-1:0] w_difs_last, w_slot_last;
  logic [3:0]         w_cw_min, w_cw_max, w_cw_up;
  logic [4:0]         w_cw_inc;
  logic [2:0]         w_retry_nxt;

  mac_lfsr16 #(.SEED(LFSR_SEED), .OUT_W(SLOT_W)) u_lfsr (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (1'b1),
    .o_q   (w_lfsr)
  );

  // A zero-length DIFS or slot behaves as a single cycle
  assign w_difs_last = (difs_top == '0) ? '0 : difs_top - TIMER_W'(1);
  assign w_slot_last = (slot_top == '0) ? '0 : slot_top - TIMER_W'(1);
  assign w_cw_min    = clamp_exp(cw_exp_min, 4'(SLOT_W));
  assign w_cw_max    = clamp_exp(cw_exp_max, 4'(SLOT_W));
  assign w_cw_inc    = {1'b0, r_cw_exp} + 5'd1;
  assign w_cw_up     = (w_cw_inc > {1'b0, w_cw_max}) ? w_cw_max : w_cw_inc[3:0];
  assign w_mask      = ~({SLOT_W{1'b1}} << r_cw_exp);
  assign w_retry_nxt = r_retry + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= 1'b0;
      r_drop     <= 1'b0;
      r_bo_valid <= 1'b0;
      r_cw_exp   <= '0;
      r_slots    <= '0;
      r_retry    <= '0;
      r_timer    <= '0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        ST_IDLE: if (tx_req) begin
          r_state    <= ST_DIFS;
          r_cw_exp   <= w_cw_min;
          r_retry    <= '0;
          r_bo_valid <= 1'b0;
          r_timer    <= '0;
        end
        ST_DIFS: begin
          if (!tx_req)  r_state <= ST_IDLE;
          else if (!ch_idle) r_timer <= '0;
          else if (r_timer == w_difs_last) begin
            r_state <= ST_BACKOFF;
            r_timer <= '0;
            // Draw only once per attempt; a resumed backoff keeps its frozen count
            if (!r_bo_valid) begin
              r_slots    <= w_lfsr & w_mask;
              r_bo_valid <= 1'b1;
            end
          end else r_timer <= r_timer + TIMER_W'(1);
        end
        ST_BACKOFF: begin
          if (!tx_req) r_state <= ST_IDLE;
          else if (!ch_idle) begin
            r_state <= ST_DIFS;
            r_timer <= '0;
          end else if (r_slots == '0) begin
            r_state <= ST_GRANT;
            r_grant <= 1'b1;
          end else if (r_timer == w_slot_last) begin
            r_slots <= r_slots - SLOT_W'(1);
            r_timer <= '0;
          end else r_timer <= r_timer + TIMER_W'(1);
        end
        ST_GRANT: if (tx_done) begin
          r_grant    <= 1'b0;
          r_bo_valid <= 1'b0;
          if (tx_ok) begin
            r_state <= ST_IDLE;
            r_retry <= '0;
          end else begin
            r_retry  <= w_retry_nxt;
            r_cw_exp <= w_cw_up;
            r_timer  <= '0;
            if (w_retry_nxt == 3'(RETRY_LIMIT)) begin
              r_state <= ST_IDLE;
              r_drop  <= 1'b1;
            end else r_state <= ST_DIFS;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_grant   = r_grant;
  assign tx_drop    = r_drop;
  assign cw_exp     = r_cw_exp;
  assign slots_left = r_slots;
  assign retry_cnt  = r_retry;
  assign state      = r_state;

endmodule
